// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART transmitter
// (XMitGo/TxEmpty handshake) between NUM_REQ byte-stream sources.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_last,
  input  logic [NUM_REQ*8-1:0] i_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [NUM_REQ-1:0]   o_grant,
  input  logic                 i_tx_empty,
  output logic                 o_xmit_go,
  output logic [7:0]           o_tx_data,
  output logic                 o_busy,
  output logic                 o_timeout_err,
  output logic [1:0]           o_state
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a byte is offered to the UART while o_xmit_go=1 with o_tx_data
  // stable; the UART takes it by dropping i_tx_empty, after which the owner
  // gets a one-cycle o_ack and must present its next byte on the following cycle.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state, w_state_n;
  logic [NUM_REQ-1:0] r_grant, w_grant_n;
  logic [NUM_REQ-1:0] r_ack, w_ack_n;
  logic               r_xmit, w_xmit_n;
  logic [7:0]         r_tx_data, w_tx_data_n;
  logic               r_terr, w_terr_n;
  logic               r_busy, w_busy_n;
  logic [IW-1:0]      r_ptr, w_ptr_n;
  logic [IW-1:0]      r_idx, w_idx_n;
  logic               r_last, w_last_n;
  logic [7:0]         r_burst, w_burst_n;
  logic [15:0]        r_timer, w_timer_n;

  logic               w_found;
  logic [IW-1:0]      w_pick;
  logic [IW-1:0]      w_cand;
  logic [IW-1:0]      w_ptr_next;

  // First requester at or after the rotation pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_ptr_next = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + IW'(1);

  always_comb begin
    w_state_n   = r_state;
    w_grant_n   = r_grant;
    w_ack_n     = '0;
    w_xmit_n    = r_xmit;
    w_tx_data_n = r_tx_data;
    w_terr_n    = 1'b0;
    w_ptr_n     = r_ptr;
    w_idx_n     = r_idx;
    w_last_n    = r_last;
    w_burst_n   = r_burst;
    w_timer_n   = r_timer;
    case (r_state)
      S_IDLE: begin
        if (i_tx_empty && w_found) begin
          w_state_n   = S_SEND;
          w_idx_n     = w_pick;
          w_grant_n   = NUM_REQ'(1) << w_pick;
          w_tx_data_n = i_data[8*w_pick +: 8];
          w_last_n    = i_last[w_pick];
          w_burst_n   = 8'd1;
          w_xmit_n    = 1'b1;
          w_timer_n   = '0;
        end
      end
      S_SEND: begin
        if (!i_tx_empty) begin
          w_xmit_n  = 1'b0;
          w_ack_n   = r_grant;
          w_state_n = S_DRAIN;
        end else if (r_timer == 16'(TIMEOUT)) begin
          w_xmit_n  = 1'b0;
          w_terr_n  = 1'b1;
          w_grant_n = '0;
          w_ptr_n   = w_ptr_next;
          w_state_n = S_IDLE;
        end else begin
          w_timer_n = r_timer + 16'd1;
        end
      end
      S_DRAIN: begin
        w_xmit_n = 1'b0;
        // Skip the Ack cycle itself so the owner has presented its next byte.
        if (i_tx_empty && (r_ack == '0)) begin
          if (r_last || (r_burst == 8'(MAX_BURST)) || !i_req[r_idx]) begin
            w_grant_n = '0;
            w_ptr_n   = w_ptr_next;
            w_state_n = S_IDLE;
          end else begin
            w_tx_data_n = i_data[8*r_idx +: 8];
            w_last_n    = i_last[r_idx];
            w_burst_n   = (r_burst == 8'(MAX_BURST)) ? r_burst : r_burst + 8'd1;
            w_xmit_n    = 1'b1;
            w_timer_n   = '0;
            w_state_n   = S_SEND;
          end
        end
      end
      default: begin
        w_state_n   = S_IDLE;
        w_grant_n   = '0;
        w_xmit_n    = 1'b0;
        w_tx_data_n = 8'h00;
      end
    endcase
    w_busy_n = |w_grant_n;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_ack     <= '0;
      r_xmit    <= 1'b0;
      r_tx_data <= 8'h00;
      r_terr    <= 1'b0;
      r_busy    <= 1'b0;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_last    <= 1'b0;
      r_burst   <= 8'd0;
      r_timer   <= 16'd0;
    end else begin
      r_state   <= w_state_n;
      r_grant   <= w_grant_n;
      r_ack     <= w_ack_n;
      r_xmit    <= w_xmit_n;
      r_tx_data <= w_tx_data_n;
      r_terr    <= w_terr_n;
      r_busy    <= w_busy_n;
      r_ptr     <= w_ptr_n;
      r_idx     <= w_idx_n;
      r_last    <= w_last_n;
      r_burst   <= w_burst_n;
      r_timer   <= w_timer_n;
    end
  end

  assign o_ack         = r_ack;
  assign o_grant       = r_grant;
  assign o_xmit_go     = r_xmit;
  assign o_tx_data     = r_tx_data;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_terr;
  assign o_state       = r_state;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter (XMitGo/TxEmpty handshake, 8-bit TxData) between NUM_REQ byte-stream sources, e.g. several message drivers.
- Round-robin arbitration, packet-granular: a grant is held until the requester's Last byte, Req drop, or MAX_BURST bytes sent.
- Sits between the driver FSMs and the UART TX core; drives the UART exactly as a single driver would.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 16, max bytes per grant before forced rotation (1..255)
TIMEOUT, 1023, cycles allowed in SEND for the UART to drop TxEmpty before abort (1..65535)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Req  in  NUM_REQ  per-requester byte available, level
Last  in  NUM_REQ  per-requester: presented byte is final of packet
Data  in  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i]
Ack  out  NUM_REQ  one-cycle pulse: requester's presented byte accepted by the UART; present next byte next cycle
Grant  out  NUM_REQ  one-hot current owner, all-zero when idle
TxEmpty  in  1  UART ready/empty; falls when UART accepts a byte
XMitGo  out  1  transmit request to UART
TxData  out  8  byte to UART, registered
Busy  out  1  high whenever Grant is non-zero
TimeoutErr  out  1  one-cycle pulse on SEND timeout

Behaviour:
- Reset (async): state IDLE, Grant=0, Ack=0, XMitGo=0, TxData=8'h00, TimeoutErr=0, rr pointer=0, burst count=0, timer=0.
- All outputs registered.
- IDLE:
  - If TxEmpty=1 and Req!=0, pick the first set Req at or after the rr pointer, wrapping modulo NUM_REQ.
  - Same edge: Grant<=onehot(w), TxData<=Data[w], latch Last[w], burst count<=1, XMitGo<=1, timer<=0; go SEND.
  - Latency: XMitGo high 1 cycle after Req and TxEmpty are sampled.
- SEND: XMitGo held 1; timer increments.
  - TxEmpty sampled 0: XMitGo<=0, Ack[w]<=1 for one cycle, go DRAIN.
  - Else if timer==TIMEOUT: XMitGo<=0, TimeoutErr pulse, release.
- DRAIN: XMitGo=0; wait for TxEmpty=1. Then:
  - Release if the latched Last=1, or burst count==MAX_BURST, or Req[w]=0.
  - Otherwise continue: TxData<=Data[w], latch Last[w], burst count+1, XMitGo<=1, timer<=0; back to SEND with Grant unchanged.
  - Continue is evaluated the cycle after the Ack pulse at the earliest, so the requester has updated Data.
- Release: Grant<=0, rr pointer<=(w+1) mod NUM_REQ, go IDLE.
  - Re-arbitration needs at least 1 idle cycle, so Grant is never switched on the same edge it is cleared.
- Req drop during SEND: the latched byte is still sent and Acked; the grant releases in DRAIN.
- Req/Data of non-granted requesters are ignored; no Ack is ever issued to a non-granted requester.
- Simultaneous requests: rotation order from the pointer; a single persistent requester may be re-granted immediately if no other Req is set.
- TxEmpty=0 in IDLE: no grant is issued, Req is held off.
- Reset asserted mid-SEND: XMitGo drops asynchronously; the byte is lost and no Ack is issued.
- State encoding is unused-safe: any illegal state returns to IDLE with outputs cleared.
- Burst count is 8 bits; it saturates at MAX_BURST and never wraps.

Test Plan:
1. Single requester. Req[0]=1, Data[0]=8'h48, Last[0]=1; UART model drops TxEmpty 2 cycles after XMitGo and restores it 10 cycles later.
   -> Grant=0001, TxData=48, one Ack[0] pulse, XMitGo low after TxEmpty falls, Grant=0 after TxEmpty returns.
2. Packet hold. Req[1] sends "Hi\n" (48,69,0A; Last on 0A) while Req[2] is held high.
   -> Req[1] receives three Acks and all three bytes go out consecutively before Grant=0100 appears.
3. Round-robin fairness. Req=1111, each requester sends single-byte packets with Last=1, pointer starts at 0.
   -> Grant order is 0001, 0010, 0100, 1000, 0001.
4. Burst limit. MAX_BURST=4; Req[0] streams 10 bytes (Last never set) while Req[3] is pending.
   -> After 4 Acks, Grant switches to 1000; Req[0] resumes after Req[3] completes.
5. Timeout. TIMEOUT=20; the UART model never drops TxEmpty.
   -> XMitGo high for 21 cycles, TimeoutErr pulses once, no Ack, Grant=0, rr pointer advances.
6. Reset mid-operation. Assert Reset during SEND (XMitGo=1).
   -> XMitGo, Grant, Ack and TxData are 0 immediately, without waiting for a clock edge.
   -> After release, Req[2] alone is granted first (pointer=0, search finds 2).
